// File: rtl/alu_pipe_pkg.sv
// Shared definitions for alu_pipe: op codes, FSM state codes and the registered flag bundle.
package alu_pipe_pkg;

   localparam logic [2:0] OP_AND  = 3'd0;
   localparam logic [2:0] OP_OR   = 3'd1;
   localparam logic [2:0] OP_ADD  = 3'd2;
   localparam logic [2:0] OP_MUL  = 3'd3;
   localparam logic [2:0] OP_XOR  = 3'd4;
   localparam logic [2:0] OP_SLT  = 3'd5;
   localparam logic [2:0] OP_SUB  = 3'd6;
   localparam logic [2:0] OP_SLTU = 3'd7;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUSY = 2'd1;
   localparam logic [1:0] ST_HOLD = 2'd2;

   typedef struct packed {
      logic zero;
      logic neg;
      logic carry;
      logic ovf;
      logic err;
   } flags_t;

endpackage

// File: rtl/alu_pipe_mul.sv
// Iterative shift-add multiplier: one partial-product step per clock, low WIDTH bits of a*b.
// done is asserted during the final step; p carries the finished product in that same cycle.
module alu_pipe_mul #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             done,
   output logic [WIDTH-1:0] p
);

   localparam int CW = $clog2(WIDTH + 1);

   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] mcand_p0;
   logic [WIDTH-1:0] mplier_p0;
   logic [WIDTH-1:0] acc_p0;
   logic [WIDTH-1:0] acc_nxt;

   assign acc_nxt = acc_p0 + (mplier_p0[0] ? mcand_p0 : '0);
   assign done    = (cnt == CW'(1));
   assign p       = acc_nxt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (start) begin
         cnt <= CW'(WIDTH);
      end else if (cnt != '0) begin
         cnt <= cnt - CW'(1);
      end
   end

   // Datapath needs no reset: it is reloaded on every start and only observed via done.
   always_ff @(posedge clk) begin
      if (start) begin
         mcand_p0  <= a;
         mplier_p0 <= b;
         acc_p0    <= '0;
      end else if (cnt != '0) begin
         mcand_p0  <= {mcand_p0[WIDTH-2:0], 1'b0};
         mplier_p0 <= mplier_p0 >> 1;
         acc_p0    <= acc_nxt;
      end
   end

endmodule

// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready handshake, pass-through tag and flag outputs.
// Define ALU_PIPE_MUL_EN to make op 3 an iterative multiply; otherwise op 3 is illegal.
module alu_pipe
   import alu_pipe_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       f,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] y,
   output logic [TAG_W-1:0] out_tag,
   output logic             zero,
   output logic             neg,
   output logic             carry,
   output logic             ovf,
   output logic             err
);

   logic [1:0]              state;
   flags_t                  flg;
   flags_t                  flg_p0;
   logic [WIDTH-1:0]        res_p0;
   logic [WIDTH:0]          sum_p0;
   logic [WIDTH:0]          dif_p0;
   logic signed [WIDTH-1:0] as_p0;
   logic signed [WIDTH-1:0] bs_p0;
   logic                    accept;
   logic                    go_busy;

   assign in_ready  = (state == ST_IDLE) | ((state == ST_HOLD) & out_ready);
   assign accept    = in_valid & in_ready;
   assign out_valid = (state == ST_HOLD);

   assign zero  = flg.zero;
   assign neg   = flg.neg;
   assign carry = flg.carry;
   assign ovf   = flg.ovf;
   assign err   = flg.err;

   assign sum_p0 = {1'b0, a} + {1'b0, b};
   assign dif_p0 = {1'b0, a} - {1'b0, b};
   assign as_p0  = a;
   assign bs_p0  = b;

   always_comb begin
      res_p0 = '0;
      flg_p0 = '0;
      case (f)
         OP_AND:  res_p0 = a & b;
         OP_OR:   res_p0 = a | b;
         OP_XOR:  res_p0 = a ^ b;
         OP_ADD: begin
            res_p0       = sum_p0[WIDTH-1:0];
            flg_p0.carry = sum_p0[WIDTH];
            flg_p0.ovf   = (a[WIDTH-1] == b[WIDTH-1]) & (sum_p0[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB: begin
            res_p0       = dif_p0[WIDTH-1:0];
            flg_p0.carry = dif_p0[WIDTH];
            flg_p0.ovf   = (a[WIDTH-1] != b[WIDTH-1]) & (dif_p0[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SLT:  res_p0 = {{(WIDTH-1){1'b0}}, (as_p0 < bs_p0)};
         OP_SLTU: res_p0 = {{(WIDTH-1){1'b0}}, (a < b)};
         // The single-cycle path never produces a multiply; with the multiplier built, this is bypassed.
         OP_MUL:  flg_p0.err = 1'b1;
      endcase
      flg_p0.zero = (res_p0 == '0);
      flg_p0.neg  = res_p0[WIDTH-1];
   end

`ifdef ALU_PIPE_MUL_EN
   logic             mul_done;
   logic [WIDTH-1:0] mul_p;

   assign go_busy = (f == OP_MUL);

   alu_pipe_mul #(.WIDTH(WIDTH)) u_mul (
      .clk   (clk),
      .rst_n (rst_n),
      .start (accept & go_busy),
      .a     (a),
      .b     (b),
      .done  (mul_done),
      .p     (mul_p)
   );
`else
   assign go_busy = 1'b0;
`endif

   // Output register stage: result, flags and tag move together into HOLD.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         y       <= '0;
         out_tag <= '0;
         flg     <= '0;
      end else if (accept) begin
         out_tag <= in_tag;
         if (go_busy) begin
            state <= ST_BUSY;
         end else begin
            state <= ST_HOLD;
            y     <= res_p0;
            flg   <= flg_p0;
         end
      end else if ((state == ST_HOLD) & out_ready) begin
         state <= ST_IDLE;
`ifdef ALU_PIPE_MUL_EN
      end else if ((state == ST_BUSY) & mul_done) begin
         state <= ST_HOLD;
         y     <= mul_p;
         flg   <= '{zero: (mul_p == '0), neg: mul_p[WIDTH-1], carry: 1'b0, ovf: 1'b0, err: 1'b0};
`endif
      end
   end

endmodule
